// File: rtl/toggle_cover_detect_pkg.sv
// Shared sizing and cover-point index helpers for the toggle coverage detector.
package toggle_cover_detect_pkg;

  function automatic int npt(input int sig_w);
    return 2 * sig_w;
  endfunction

  function automatic int cnt_w(input int sig_w);
    return $clog2(2 * sig_w + 1);
  endfunction

  function automatic int pt_rise(input int i);
    return 2 * i;
  endfunction

  function automatic int pt_fall(input int i);
    return 2 * i + 1;
  endfunction

endpackage

// File: rtl/toggle_cover_detect_if.sv
// Monitored-signal bundle and cover outputs; master drives stimulus, slave is the detector.
interface toggle_cover_detect_if #(
  parameter int SIG_W = 11
);
  import toggle_cover_detect_pkg::*;

  localparam int NPT   = npt(SIG_W);
  localparam int CNT_W = cnt_w(SIG_W);

  logic             en;
  logic             clear;
  logic [SIG_W-1:0] sig;
  logic [NPT-1:0]   valid;
  logic [CNT_W-1:0] covered_cnt;
  logic             all_covered;

  modport master (
    output en, clear, sig,
    input  valid, covered_cnt, all_covered
  );

  modport slave (
    input  en, clear, sig,
    output valid, covered_cnt, all_covered
  );

endinterface

// File: rtl/toggle_cover_detect_bit.sv
// One monitored bit: sampled history, sticky rise/fall hit mask, registered cover pulses.
// Index 0 of each 2-bit bus is the rise point, index 1 the fall point.
module toggle_cover_detect_bit #(
  parameter int ONCE = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       en,
  input  logic       armed,
  input  logic       clear,
  input  logic       sig_i,
  output logic [1:0] valid_o,
  output logic [1:0] mask_nxt_o
);

  logic       sig_q,   sig_d;
  logic [1:0] mask_q,  mask_d;
  logic [1:0] valid_q, valid_d;
  logic [1:0] hit;

  always_comb begin
    hit     = 2'b00;
    sig_d   = sig_q;
    if (en) begin
      sig_d = sig_i;
      if (armed) begin
        hit = {~sig_i & sig_q, sig_i & ~sig_q};
      end
    end
    // Clear wins over a hit on the same edge, so that toggle is dropped entirely.
    mask_d  = clear ? 2'b00 : (mask_q | hit);
    if (clear) begin
      valid_d = 2'b00;
    end else if (ONCE != 0) begin
      valid_d = hit & ~mask_q;
    end else begin
      valid_d = hit;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sig_q   <= 1'b0;
      mask_q  <= 2'b00;
      valid_q <= 2'b00;
    end else begin
      sig_q   <= sig_d;
      mask_q  <= mask_d;
      valid_q <= valid_d;
    end
  end

  assign valid_o    = valid_q;
  assign mask_nxt_o = mask_d;

endmodule

// File: rtl/toggle_cover_detect.sv
// Per-bit toggle cover detector: one-cycle registered pulse per rise/fall point, optional
// report-once masking, and a running count of covered points.
module toggle_cover_detect
  import toggle_cover_detect_pkg::*;
#(
  parameter int SIG_W = 11,
  parameter int ONCE  = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  toggle_cover_detect_if.slave  bus
);

  localparam int NPT   = npt(SIG_W);
  localparam int CNT_W = cnt_w(SIG_W);

  localparam logic [0:0] ST_UNPRIMED = 1'b0;
  localparam logic [0:0] ST_ARMED    = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             all_q,   all_d;
  logic [NPT-1:0]   valid_all;
  logic [NPT-1:0]   mask_nxt;
  logic             armed;

  assign armed = (state_q == ST_ARMED);

  for (genvar i = 0; i < SIG_W; i++) begin : g_bit
    logic [1:0] bit_vld;
    logic [1:0] bit_mask;

    toggle_cover_detect_bit #(
      .ONCE (ONCE)
    ) u_bit (
      .clock      (clock),
      .reset      (reset),
      .en         (bus.en),
      .armed      (armed),
      .clear      (bus.clear),
      .sig_i      (bus.sig[i]),
      .valid_o    (bit_vld),
      .mask_nxt_o (bit_mask)
    );

    assign valid_all[pt_rise(i)] = bit_vld[0];
    assign valid_all[pt_fall(i)] = bit_vld[1];
    assign mask_nxt[pt_rise(i)]  = bit_mask[0];
    assign mask_nxt[pt_fall(i)]  = bit_mask[1];
  end

  // Any gap in sampling drops the baseline; the next enabled edge only re-captures sig.
  always_comb begin
    state_d = bus.en ? ST_ARMED : ST_UNPRIMED;
  end

  always_comb begin
    cnt_d = '0;
    for (int p = 0; p < NPT; p++) begin
      cnt_d = cnt_d + CNT_W'(mask_nxt[p]);
    end
    all_d = (cnt_d == CNT_W'(NPT));
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_UNPRIMED;
      cnt_q   <= '0;
      all_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      all_q   <= all_d;
    end
  end

  assign bus.valid       = valid_all;
  assign bus.covered_cnt = cnt_q;
  assign bus.all_covered = all_q;

endmodule
